layer_mem_arb: RTL
==================

# layer_mem_arb

Arbiter that shares the single layer-memory port (`crd`/`cwr`/`csel`/`caddr_rd`/`caddr_wr`/`cdata_wr`/`cdata_rd`) of the CONV accelerator among NREQ internal engines: convolution writer, max-pool reader/writer and flatten reader/writer. Grants are round-robin with burst lock. Command outputs are registered, and read data is returned with requester ID one cycle after the `crd` strobe. It sits between the layer engines and the top-level CONV memory pins.

## Interface
- NREQ, 3, number of requesters (index 0 = conv, 1 = pool, 2 = flatten)
- AW, 12, memory address width
- DW, 20, memory data width
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- req_valid  in  NREQ  beat request per requester
- req_we  in  NREQ  1 = write beat, 0 = read beat
- req_sel  in  3*NREQ  target bank per requester (1..5 legal)
- req_addr  in  AW*NREQ  beat address
- req_wdata  in  DW*NREQ  write data
- req_last  in  NREQ  final beat of burst; releases lock
- req_ready  out  NREQ  grant; beat accepted when valid & ready
- crd, cwr  out  1  read / write strobe to layer memory
- csel  out  3  bank select
- caddr_rd, caddr_wr  out  AW  read / write address
- cdata_wr  out  DW  write data
- cdata_rd  in  DW  read data; valid at the rising edge closing a `crd` cycle
- rvalid  out  1  returned read data valid
- rid  out  clog2(NREQ)  requester owning `rdata`
- rdata  out  DW  returned read data
- err_sel  out  1  sticky: illegal `csel` beat seen
- arb_idle  out  1  no lock held and no strobe in flight

## Operation
- States: IDLE, LOCKED(owner). The round-robin pointer `ptr` resets to 0.
- IDLE: the winner is the first requester with `req_valid` high, searching from `ptr` upward with wrap.
  - `req_ready` is high only for the winner and is combinational on `req_valid`.
- Accept in IDLE:
  - with `req_last=0` → LOCKED(winner);
  - with `req_last=1` → stay IDLE, `ptr` = winner+1 mod NREQ.
- LOCKED(owner): `req_ready` is high only for the owner. Other requests wait.
  - Owner may drop `req_valid` without losing the lock.
  - Accept with `req_last=1` → IDLE, `ptr` = owner+1 mod NREQ.
- Accepted beat registers:
  - `csel` ← sel
  - `caddr_rd` and `caddr_wr` ← addr
  - `cdata_wr` ← wdata
  - `crd` ← !we & legal
  - `cwr` ← we & legal
- No accept: `crd`=`cwr`=0; address, data and `csel` hold their values.
- Read return: in the cycle after `crd`=1, `rvalid`=1, `rdata` = `cdata_rd` captured at that edge, `rid` = issuing requester.
- Illegal sel (0, 6, 7):
  - beat is consumed; no strobe; `err_sel` set (sticky until reset);
  - a read beat still returns `rvalid`=1 with `rdata`=0 and the correct `rid`, so requesters never hang.
- `arb_idle` = (state==IDLE) & !`crd` & !`cwr` & !`rvalid`.

## Timing
- Reset values: all strobes 0, `csel`=0, addresses 0, `cdata_wr`=0, `rvalid`=0, `rid`=0, `rdata`=0, `err_sel`=0, `arb_idle`=1, `req_ready`=0, state IDLE, `ptr`=0.
- Accept at edge k → strobe high for cycle k..k+1. For reads, `rvalid` is high for cycle k+1..k+2.
- Throughput is one beat per cycle. Back-to-back beats from different requesters in IDLE are allowed with no bubble.
- A write followed by a read of the same address on the next beat returns the new data. The memory writes on the rising edge and reads on the falling edge, so no forwarding is needed.
- Asynchronous reset mid-burst releases the lock immediately. Any in-flight `rvalid` is dropped.
- `cdata_rd` is only sampled when the previous cycle had `crd`=1. Otherwise it is ignored, including when X.

## Configuration
- `LMARB_FIXED_PRIO_EN` defined: fixed priority, requester 0 highest. `ptr` is held at 0 and never updated. Burst lock is unchanged.
- Undefined (default): round-robin as described above.

## Test plan
- **Reset:** assert `reset`=0 mid-burst with `crd`=1 → all outputs at reset values within the same cycle; `arb_idle`=1 after release.
- **Contention:** all 3 requesters issue single-beat reads (`req_last`=1) continuously → grant order 0,1,2,0,1,2. With `LMARB_FIXED_PRIO_EN` defined → 0 every cycle.
- **Burst lock:** requester 1 issues 4 writes, sel=3, addr 0x000..0x003, `last` on the 4th, with an idle gap after beat 2; requester 0 requests throughout → requester 0 is granted only after beat 4; memory bank 3 holds the 4 values.
- **Read latency:** requester 2 reads sel=5, addr 0x7FF, memory preloaded 0xABCDE → `crd` one cycle after accept; `rvalid`=1, `rid`=2, `rdata`=0xABCDE one cycle after that.
- **Illegal sel:** requester 0 reads with sel=6 → no `crd`; `rvalid`=1 with `rdata`=0 and `rid`=0; `err_sel`=1 and stays set.
- **Write-then-read:** write sel=1, addr 0x040, data 0x12345, then read the same location on the next beat → `rdata`=0x12345.

Source files
------------

// File: rtl/layer_mem_arb.sv
// layer_mem_arb: shares the single CONV layer-memory port among NREQ engines
// (0 = conv, 1 = pool, 2 = flatten). Round-robin grant with burst lock,
// registered memory commands, read data returned with requester id one cycle
// after the crd strobe.
// Build option: LMARB_FIXED_PRIO_EN selects fixed priority (requester 0 highest).
module layer_mem_arb #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned AW   = 12,
    parameter int unsigned DW   = 20,
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_we,
    input  logic [3*NREQ-1:0] req_sel,
    input  logic [AW*NREQ-1:0] req_addr,
    input  logic [DW*NREQ-1:0] req_wdata,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic              crd,
    output logic              cwr,
    output logic [2:0]        csel,
    output logic [AW-1:0]     caddr_rd,
    output logic [AW-1:0]     caddr_wr,
    output logic [DW-1:0]     cdata_wr,
    input  logic [DW-1:0]     cdata_rd,
    output logic              rvalid,
    output logic [IDW-1:0]    rid,
    output logic [DW-1:0]     rdata,
    output logic              err_sel,
    output logic              arb_idle
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   owner_q, owner_d;
    logic [IDW-1:0]   ptr_q, ptr_d;

    logic [IDW-1:0]   gidx_c;
    logic             accept_c;
    logic [NREQ-1:0]  ready_c;
    logic [2:0]       sel_c;
    logic [AW-1:0]    addr_c;
    logic [DW-1:0]    wdata_c;
    logic             we_c;
    logic             last_c;
    logic             legal_c;
    int unsigned      idx;

    // Read-return tracking: a read beat (legal or not) was accepted last edge
    logic             rd_pend;
    logic             rd_ill;
    logic [IDW-1:0]   rd_id;

    // Arbitration state, lock owner and round-robin pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    // Winner selection, beat mux and next-state logic
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        gidx_c   = owner_q;
        accept_c = 1'b0;
        ready_c  = '0;
        idx      = 0;

        if (state_q == IDLE) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                idx = 32'(ptr_q) + i;
                if (idx >= NREQ) idx = idx - NREQ;
                if (!accept_c && req_valid[idx]) begin
                    accept_c = 1'b1;
                    gidx_c   = IDW'(idx);
                end
            end
        end else begin
            accept_c = req_valid[owner_q];
        end

        if (accept_c) ready_c[gidx_c] = 1'b1;

        sel_c   = req_sel[32'(gidx_c)*3 +: 3];
        addr_c  = req_addr[32'(gidx_c)*AW +: AW];
        wdata_c = req_wdata[32'(gidx_c)*DW +: DW];
        we_c    = req_we[gidx_c];
        last_c  = req_last[gidx_c];
        legal_c = (sel_c >= 3'd1) && (sel_c <= 3'd5);

        if (accept_c) begin
            if (last_c) begin
                state_d = IDLE;
`ifdef LMARB_FIXED_PRIO_EN
                ptr_d   = '0;
`else
                ptr_d   = (32'(gidx_c) == NREQ - 1) ? '0 : gidx_c + IDW'(1);
`endif
            end else begin
                state_d = LOCKED;
                owner_d = gidx_c;
            end
        end
    end

    // Grants are held low while reset is asserted
    assign req_ready = ready_c & {NREQ{reset}};

    // Registered memory command, read return and sticky error
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            crd      <= 1'b0;
            cwr      <= 1'b0;
            csel     <= '0;
            caddr_rd <= '0;
            caddr_wr <= '0;
            cdata_wr <= '0;
            rd_pend  <= 1'b0;
            rd_ill   <= 1'b0;
            rd_id    <= '0;
            rvalid   <= 1'b0;
            rid      <= '0;
            rdata    <= '0;
            err_sel  <= 1'b0;
        end else begin
            crd     <= accept_c & ~we_c & legal_c;
            cwr     <= accept_c & we_c & legal_c;
            rd_pend <= accept_c & ~we_c;
            rd_ill  <= accept_c & ~we_c & ~legal_c;
            if (accept_c) begin
                csel     <= sel_c;
                caddr_rd <= addr_c;
                caddr_wr <= addr_c;
                cdata_wr <= wdata_c;
                rd_id    <= gidx_c;
            end
            if (accept_c && !legal_c) err_sel <= 1'b1;
            rvalid <= rd_pend;
            // cdata_rd is only looked at when a legal read strobe just closed
            if (rd_pend) begin
                rid   <= rd_id;
                rdata <= rd_ill ? '0 : cdata_rd;
            end
        end
    end

    assign arb_idle = (state_q == IDLE) & ~crd & ~cwr & ~rvalid;

endmodule
